instruction_encoder_loader: RTL and testbench

//  Packs field-level instruction requests (type, opcode, rs1/rs2/rd, imm, SA, stop) into 32-bit words using the core's
//  R/J/I/S formats and writes them sequentially into instruction memory over a req/ack port. It is the encoder

---
 rtl/instruction_encoder_loader.sv | 183 ++++++++++++++++++
 tb/tb_instruction_encoder_loader.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/instruction_encoder_loader.sv
// instruction_encoder_loader
//   Packs field-level instruction requests into 32-bit R/J/I/S words and writes them
//   sequentially into instruction memory over a req/ack write port.
// Ports:
//   clk, rst                    clock, synchronous active-low reset
//   start, base_addr            begin a load session at base_addr (ignored while busy)
//   in_valid/in_ready, in_*     instruction field handshake
//   mem_req/mem_ack             write request held until acknowledged
//   mem_addr, mem_wdata         write word address and encoded instruction
//   busy, done, count           session status and words written this session
//   err_opcode, err_full        sticky errors: illegal opcode dropped, DEPTH reached early
module instruction_encoder_loader #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_type,
  input  logic [4:0]        in_opcode,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [4:0]        in_rd,
  input  logic [13:0]       in_imm14,
  input  logic [23:0]       in_imm24,
  input  logic [4:0]        in_sa,
  input  logic              in_stop,
  output logic              mem_req,
  input  logic              mem_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   count,
  output logic              err_opcode,
  output logic              err_full
);

  typedef enum logic [1:0] {StIdle, StAccept, StWrite, StDone} state_e;

  localparam logic [ADDR_W:0] DepthC = (ADDR_W+1)'(DEPTH);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              mem_req_q, mem_req_d;
  logic              done_q, done_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              err_opcode_q, err_opcode_d;
  logic              err_full_q, err_full_d;

  logic [31:0]       enc_word;
  logic              enc_legal;
  logic [ADDR_W:0]   count_inc;

  // Field packing and opcode legality for the incoming request
  always_comb begin
    enc_word        = '0;
    enc_word[31]    = in_stop;
    enc_word[30:29] = in_type;
    enc_word[4:0]   = in_opcode;
    enc_legal       = 1'b0;
    unique case (in_type)
      2'b00: begin
        enc_word[9:5]   = in_rs1;
        enc_word[14:10] = in_rd;
        enc_word[19:15] = in_rs2;
        enc_legal       = (in_opcode < 5'd4);
      end
      2'b01: begin
        enc_word[28:5]  = in_imm24;
        enc_legal       = (in_opcode < 5'd2);
      end
      2'b10: begin
        enc_word[9:5]   = in_rs1;
        enc_word[14:10] = in_rd;
        enc_word[28:15] = in_imm14;
        enc_legal       = (in_opcode < 5'd5);
      end
      2'b11: begin
        enc_word[9:5]   = in_rs1;
        enc_word[14:10] = in_rd;
        enc_word[19:15] = in_rs2;
        enc_word[24:20] = in_sa;
        enc_legal       = (in_opcode < 5'd4);
      end
      default: ;
    endcase
  end

  assign count_inc = count_q + 1'b1;

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_req_d    = mem_req_q;
    done_d       = done_q;
    count_d      = count_q;
    err_opcode_d = err_opcode_q;
    err_full_d   = err_full_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d      = StAccept;
          wr_ptr_d     = base_addr;
          count_d      = '0;
          err_opcode_d = 1'b0;
          err_full_d   = 1'b0;
          done_d       = 1'b0;
        end
      end
      StAccept: begin
        if (in_valid) begin
          if (enc_legal) begin
            mem_wdata_d = enc_word;
            mem_addr_d  = wr_ptr_q;
            mem_req_d   = 1'b1;
            state_d     = StWrite;
          end else begin
            // Illegal pair is dropped; stop bit on it does not end the session
            err_opcode_d = 1'b1;
          end
        end
      end
      StWrite: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          wr_ptr_d  = wr_ptr_q + 1'b1;
          count_d   = count_inc;
          if (mem_wdata_q[31] || (count_inc == DepthC)) begin
            state_d    = StDone;
            done_d     = 1'b1;
            err_full_d = ~mem_wdata_q[31];
          end else begin
            state_d = StAccept;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= StIdle;
      wr_ptr_q     <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_req_q    <= 1'b0;
      done_q       <= 1'b0;
      count_q      <= '0;
      err_opcode_q <= 1'b0;
      err_full_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_req_q    <= mem_req_d;
      done_q       <= done_d;
      count_q      <= count_d;
      err_opcode_q <= err_opcode_d;
      err_full_q   <= err_full_d;
    end
  end

  assign in_ready   = (state_q == StAccept);
  assign busy       = (state_q == StAccept) || (state_q == StWrite);
  assign mem_req    = mem_req_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign done       = done_q;
  assign count      = count_q;
  assign err_opcode = err_opcode_q;
  assign err_full   = err_full_q;

endmodule

// File: tb/tb_instruction_encoder_loader.sv
// Directed bench for instruction_encoder_loader (DEPTH overridden to 4 to reach the full limit).
module tb_instruction_encoder_loader;
  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst, start, in_valid, in_ready, in_stop;
  logic [ADDR_W-1:0] base_addr, mem_addr;
  logic [1:0]        in_type;
  logic [4:0]        in_opcode, in_rs1, in_rs2, in_rd, in_sa;
  logic [13:0]       in_imm14;
  logic [23:0]       in_imm24;
  logic              mem_req, mem_ack, busy, done, err_opcode, err_full;
  logic [31:0]       mem_wdata;
  logic [ADDR_W:0]   count;

  int checks   = 0;
  int failures = 0;

  instruction_encoder_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_type(in_type), .in_opcode(in_opcode),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_imm14(in_imm14),
    .in_imm24(in_imm24), .in_sa(in_sa), .in_stop(in_stop),
    .mem_req(mem_req), .mem_ack(mem_ack), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .count(count), .err_opcode(err_opcode), .err_full(err_full)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic put(input logic [1:0] t, input logic [4:0] op, input logic [4:0] rs1,
                     input logic [4:0] rs2, input logic [4:0] rd, input logic [13:0] i14,
                     input logic [23:0] i24, input logic [4:0] sa, input logic stop);
    in_valid = 1'b1; in_type = t; in_opcode = op; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd;
    in_imm14 = i14; in_imm24 = i24; in_sa = sa; in_stop = stop;
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; base_addr = '0; mem_ack = 1'b0;
    put(2'b00, 5'd0, 5'd0, 5'd0, 5'd0, 14'd0, 24'd0, 5'd0, 1'b0);
    in_valid = 1'b0;
    step(); step();
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_busy_done", {30'd0, busy, done}, 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);

    // Session 1 at 0x010: R word, then I word with stop and a delayed ack
    rst = 1'b1; start = 1'b1; base_addr = 10'h010;
    step();
    start = 1'b0;
    chk("accept_ready", 32'(in_ready), 32'd1);
    chk("accept_busy", 32'(busy), 32'd1);
    put(2'b00, 5'd0, 5'd1, 5'd2, 5'd3, 14'd0, 24'd0, 5'd0, 1'b0);
    step();
    in_valid = 1'b0;
    chk("r_req", 32'(mem_req), 32'd1);
    chk("r_addr", 32'(mem_addr), 32'h010);
    chk("r_wdata", mem_wdata, 32'h00010C20);
    chk("r_ready_low", 32'(in_ready), 32'd0);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    chk("r_req_drop", 32'(mem_req), 32'd0);
    chk("r_count", 32'(count), 32'd1);
    chk("r_ready_back", 32'(in_ready), 32'd1);

    put(2'b10, 5'd2, 5'd5, 5'd0, 5'd5, 14'h3FFF, 24'd0, 5'd0, 1'b1);
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("i_hold_req", 32'(mem_req), 32'd1);
      chk("i_hold_wdata", mem_wdata, 32'hDFFF94A2);
      chk("i_hold_addr", 32'(mem_addr), 32'h011);
      if (i < 3) step();
    end
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    chk("i_done", 32'(done), 32'd1);
    chk("i_count", 32'(count), 32'd2);
    chk("i_busy", 32'(busy), 32'd0);
    chk("i_err_full", 32'(err_full), 32'd0);
    chk("i_req_drop", 32'(mem_req), 32'd0);

    // Session 2 at 0x3FF: address wrap, illegal opcode, S junk masking, DEPTH limit
    start = 1'b1; base_addr = 10'h3FF;
    step();
    start = 1'b0;
    chk("s2_done_clr", 32'(done), 32'd0);
    put(2'b01, 5'd1, 5'd7, 5'd7, 5'd7, 14'h1234, 24'h800000, 5'd9, 1'b0);
    step();
    in_valid = 1'b0;
    chk("j_wdata", mem_wdata, 32'h30000001);
    chk("j_addr", 32'(mem_addr), 32'h3FF);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    put(2'b01, 5'd2, 5'd0, 5'd0, 5'd0, 14'd0, 24'h000001, 5'd0, 1'b1);
    step();
    in_valid = 1'b0;
    chk("jbad_no_req", 32'(mem_req), 32'd0);
    chk("jbad_err", 32'(err_opcode), 32'd1);
    chk("jbad_ready", 32'(in_ready), 32'd1);
    chk("jbad_count", 32'(count), 32'd1);
    chk("jbad_not_done", 32'(done), 32'd0);

    put(2'b11, 5'd3, 5'd1, 5'd2, 5'd3, 14'h3FFF, 24'hFFFFFF, 5'd31, 1'b0);
    step();
    in_valid = 1'b0;
    chk("s_wdata", mem_wdata, 32'h61F10C23);
    chk("s_addr_wrap", 32'(mem_addr), 32'h000);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    chk("s_count", 32'(count), 32'd2);

    for (int w = 0; w < 2; w++) begin
      put(2'b00, 5'd1, 5'd0, 5'd0, 5'd0, 14'd0, 24'd0, 5'd0, 1'b0);
      step();
      in_valid = 1'b0;
      chk("fill_addr", 32'(mem_addr), 32'(w + 1));
      chk("fill_wdata", mem_wdata, 32'h00000001);
      mem_ack = 1'b1;
      step();
      mem_ack = 1'b0;
    end
    chk("full_done", 32'(done), 32'd1);
    chk("full_err", 32'(err_full), 32'd1);
    chk("full_count", 32'(count), 32'd4);
    chk("full_err_opcode_sticky", 32'(err_opcode), 32'd1);
    put(2'b00, 5'd0, 5'd0, 5'd0, 5'd0, 14'd0, 24'd0, 5'd0, 1'b0);
    step();
    in_valid = 1'b0;
    chk("fifth_no_req", 32'(mem_req), 32'd0);
    chk("fifth_ready", 32'(in_ready), 32'd0);
    chk("fifth_count", 32'(count), 32'd4);

    // Reset in the middle of a pending write
    start = 1'b1; base_addr = 10'h020;
    step();
    start = 1'b0;
    chk("s3_err_clr", {30'd0, err_opcode, err_full}, 32'd0);
    put(2'b00, 5'd2, 5'd1, 5'd1, 5'd1, 14'd0, 24'd0, 5'd0, 1'b0);
    step();
    in_valid = 1'b0;
    chk("mid_req", 32'(mem_req), 32'd1);
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk("mid_rst_req", 32'(mem_req), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_wdata", mem_wdata, 32'd0);
    step();
    chk("idle_ignores_valid", 32'(in_ready), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
